// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and buffered MDU results
// into one registered register-file write stream, and keeps a busy scoreboard
// of registers with outstanding MDU writes for issue-stage hazard detection.
module wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  output logic        hazard,
  output logic        wen,
  output logic [4:0]  waddr,
  output logic [31:0] wdata
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W  = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  wb_entry_t         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve;
  logic [NREGS-1:0]  busy;

  wb_entry_t         head;
  wb_entry_t         sel;
  logic              sel_valid;
  logic              fifo_empty;
  logic              fifo_full;
  logic              starve_hit;
  logic              push;
  logic              pop;
  logic              busy_set;
  logic [NREGS-1:0]  busy_next;
  logic [STV_W-1:0]  starve_next;
  logic [CNT_W-1:0]  count_next;

  // FIFO status and handshake
  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign mdu_ready  = !fifo_full;
  assign push       = mdu_valid && !fifo_full;
  assign starve_hit = !fifo_empty && (starve == STV_W'(STARVE_MAX));

  // Writeback source selection: starved head, then ALU, then head
  always_comb begin
    sel_valid = 1'b0;
    sel       = head;
    pop       = 1'b0;
    alu_stall = 1'b0;
    if (starve_hit) begin
      sel_valid = 1'b1;
      pop       = 1'b1;
      alu_stall = alu_valid;
    end else if (alu_valid) begin
      sel_valid = 1'b1;
      sel.rd    = alu_rd;
      sel.data  = alu_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      pop       = 1'b1;
    end
  end

  // FIFO occupancy and starvation counter next state
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
    starve_next = starve;
    if (fifo_empty || pop) begin
      starve_next = '0;
    end else if (starve != STV_W'(STARVE_MAX)) begin
      starve_next = starve + STV_W'(1);
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{rd: mdu_rd, data: mdu_data};
    end
  end

  // FIFO pointers, occupancy and starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count_next;
      starve <= starve_next;
    end
  end

  // Scoreboard hazard covers RAW on both sources and WAW on the destination
  assign hazard   = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd];
  assign busy_set = issue_valid && issue_long && !hazard && (issue_rd != '0);

  // Scoreboard update: a new long op claiming a register beats its retirement
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head.rd] = 1'b0;
    if (busy_set) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Registered write port; address/data hold when nothing is selected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (sel_valid) begin
      wen   <= (sel.rd != '0);
      waddr <= sel.rd;
      wdata <= sel.data;
    end else begin
      wen   <= 1'b0;
    end
  end

endmodule
